kbd_typeahead: RTL and testbench

Keyboard PIA port for the Apple-1 core: replaces the single-byte keyboard register at 0xD010/0xD011 with a type-ahead FIFO between the PS/2 ASCII decoder (upstream) and the CPU data-in mux (downstream). It accepts decoded 7-bit ASCII key strobes, queues them, and presents them to the 6502 with Apple-1 PIA semantics:
- KBD (0xD010): key data, bit 7 set.
- KBDCR (0xD011): bit 7 = key available.

Fast typing and host paste no longer drop characters while Wozmon or BASIC is busy.

---
 rtl/apple1_pkg.sv | 7 +
 rtl/sync_fifo.sv | 67 ++++++
 rtl/kbd_typeahead.sv | 95 +++++++++
 tb/tb_kbd_typeahead.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/apple1_pkg.sv
// Shared Apple-1 constants used by the keyboard type-ahead port.
package apple1_pkg;
  localparam int KBD_ADDR_BIT    = 0;
  localparam int KBDCR_READY_BIT = 7;
  localparam int KBD_FIFO_DEPTH  = 16;
  localparam int KBD_ASCII_W     = 7;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with same-cycle push/pop and a level flush.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             pop_ok, push_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign rdata = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush && !rst) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/kbd_typeahead.sv
// Apple-1 keyboard PIA (KBD/KBDCR) backed by a type-ahead FIFO of decoded ASCII keys.
module kbd_typeahead
  import apple1_pkg::*;
#(
  parameter int DEPTH = KBD_FIFO_DEPTH
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic       cpu_clken,
  input  logic       cs,
  input  logic       address,
  input  logic       we,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       key_valid,
  input  logic [6:0] key_ascii,
  input  logic       flush,
  output logic       key_ready,
  output logic       overflow
);
  logic [7:0] dout_q, dout_d;
  logic       overflow_q, overflow_d;
  logic [5:0] cr_q, cr_d;
  logic [6:0] last_key_q, last_key_d;

  logic       fifo_full, fifo_empty;
  logic [6:0] fifo_rdata;
  logic       rd_en, wr_en, pop_req, drop;
  logic       unused_din;

  assign unused_din = ^din[7:6];

  assign rd_en   = cpu_clken && cs && !we;
  assign wr_en   = cpu_clken && cs && we;
  assign pop_req = rd_en && (address == 1'(KBD_ADDR_BIT));
  assign drop    = key_valid && fifo_full && !pop_req;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (KBD_ASCII_W)
  ) u_fifo (
    .clk   (sys_clock),
    .rst   (reset),
    .push  (key_valid),
    .pop   (pop_req),
    .flush (flush),
    .wdata (key_ascii),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    dout_d     = dout_q;
    overflow_d = overflow_q;
    cr_d       = cr_q;
    last_key_d = last_key_q;

    if (rd_en) begin
      if (address == 1'(KBD_ADDR_BIT)) begin
        dout_d = {1'b1, fifo_empty ? last_key_q : fifo_rdata};
      end else begin
        dout_d                  = {1'b0, overflow_q, cr_q};
        dout_d[KBDCR_READY_BIT] = ~fifo_empty;
      end
    end

    if (pop_req && !fifo_empty && !flush) last_key_d = fifo_rdata;

    if (wr_en && address != 1'(KBD_ADDR_BIT)) cr_d = din[5:0];

    // A drop in the same cycle as a KBDCR read must leave overflow set.
    if (flush)                                      overflow_d = 1'b0;
    else if (drop)                                  overflow_d = 1'b1;
    else if (rd_en && address != 1'(KBD_ADDR_BIT))  overflow_d = 1'b0;
  end

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      dout_q     <= 8'h00;
      overflow_q <= 1'b0;
      cr_q       <= 6'h00;
      last_key_q <= 7'h00;
    end else begin
      dout_q     <= dout_d;
      overflow_q <= overflow_d;
      cr_q       <= cr_d;
      last_key_q <= last_key_d;
    end
  end

  assign dout      = dout_q;
  assign overflow  = overflow_q;
  assign key_ready = ~fifo_empty;
endmodule

// File: tb/tb_kbd_typeahead.sv
// Directed self-checking bench for the kbd_typeahead keyboard PIA port.
module tb_kbd_typeahead;
  logic       sys_clock = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_clken = 1'b0;
  logic       cs = 1'b0;
  logic       address = 1'b0;
  logic       we = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       key_valid = 1'b0;
  logic [6:0] key_ascii = 7'h00;
  logic       flush = 1'b0;
  logic       key_ready;
  logic       overflow;

  int checks = 0;
  int failures = 0;

  kbd_typeahead #(.DEPTH(16)) dut (
    .sys_clock (sys_clock),
    .reset     (reset),
    .cpu_clken (cpu_clken),
    .cs        (cs),
    .address   (address),
    .we        (we),
    .din       (din),
    .dout      (dout),
    .key_valid (key_valid),
    .key_ascii (key_ascii),
    .flush     (flush),
    .key_ready (key_ready),
    .overflow  (overflow)
  );

  always #5 sys_clock = ~sys_clock;

  task automatic tick();
    @(posedge sys_clock);
    #1;
  endtask

  task automatic rd(input logic a);
    cpu_clken = 1'b1; cs = 1'b1; we = 1'b0; address = a;
    tick();
    cpu_clken = 1'b0; cs = 1'b0;
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    cpu_clken = 1'b1; cs = 1'b1; we = 1'b1; address = a; din = d;
    tick();
    cpu_clken = 1'b0; cs = 1'b0; we = 1'b0;
  endtask

  task automatic push(input logic [6:0] k);
    key_valid = 1'b1; key_ascii = k;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", dout); end
    checks++; if (key_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", key_ready); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    rd(1'b1);
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_kbdcr got=%h exp=00", dout); end
    rd(1'b0);
    checks++; if (dout !== 8'h80) begin failures++; $display("FAIL reset_kbd got=%h exp=80", dout); end
    checks++; if (key_ready !== 1'b0) begin failures++; $display("FAIL reset_kbd_ready got=%b exp=0", key_ready); end
  endtask

  task automatic test_single_key();
    push(7'h41);
    checks++; if (key_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", key_ready); end
    rd(1'b1);
    checks++; if (dout !== 8'h80) begin failures++; $display("FAIL single_kbdcr got=%h exp=80", dout); end
    // Read with cpu_clken low must neither latch nor pop.
    cpu_clken = 1'b0; cs = 1'b1; we = 1'b0; address = 1'b0;
    tick();
    cs = 1'b0;
    checks++; if (dout !== 8'h80) begin failures++; $display("FAIL clken_hold got=%h exp=80", dout); end
    checks++; if (key_ready !== 1'b1) begin failures++; $display("FAIL clken_nopop got=%b exp=1", key_ready); end
    rd(1'b0);
    checks++; if (dout !== 8'hC1) begin failures++; $display("FAIL single_kbd got=%h exp=C1", dout); end
    checks++; if (key_ready !== 1'b0) begin failures++; $display("FAIL single_drop got=%b exp=0", key_ready); end
    rd(1'b0);
    checks++; if (dout !== 8'hC1) begin failures++; $display("FAIL single_reread got=%h exp=C1", dout); end
    checks++; if (key_ready !== 1'b0) begin failures++; $display("FAIL single_reread_ready got=%b exp=0", key_ready); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) push(7'(8'h30 + i));
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_full_noflag got=%b exp=0", overflow); end
    push(7'h40);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    rd(1'b1);
    checks++; if (dout !== 8'hC0) begin failures++; $display("FAIL ovf_kbdcr1 got=%h exp=C0", dout); end
    rd(1'b1);
    checks++; if (dout !== 8'h80) begin failures++; $display("FAIL ovf_kbdcr2 got=%h exp=80", dout); end
    for (int i = 0; i < 16; i++) begin
      rd(1'b0);
      checks++;
      if (dout !== 8'(8'hB0 + i)) begin
        failures++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, dout, 8'(8'hB0 + i));
      end
    end
    checks++; if (key_ready !== 1'b0) begin failures++; $display("FAIL ovf_empty got=%b exp=0", key_ready); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) push(7'(8'h30 + i));
    key_valid = 1'b1; key_ascii = 7'h5A;
    cpu_clken = 1'b1; cs = 1'b1; we = 1'b0; address = 1'b0;
    tick();
    key_valid = 1'b0; cpu_clken = 1'b0; cs = 1'b0;
    checks++; if (dout !== 8'hB0) begin failures++; $display("FAIL b2b_oldest got=%h exp=B0", dout); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL b2b_ovf got=%b exp=0", overflow); end
    for (int i = 1; i < 16; i++) begin
      rd(1'b0);
      checks++;
      if (dout !== 8'(8'hB0 + i)) begin
        failures++; $display("FAIL b2b_drain%0d got=%h exp=%h", i, dout, 8'(8'hB0 + i));
      end
    end
    checks++; if (key_ready !== 1'b1) begin failures++; $display("FAIL b2b_still_one got=%b exp=1", key_ready); end
    rd(1'b0);
    checks++; if (dout !== 8'hDA) begin failures++; $display("FAIL b2b_last got=%h exp=DA", dout); end
    checks++; if (key_ready !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", key_ready); end
  endtask

  task automatic test_cr_write();
    wr(1'b1, 8'hA7);
    rd(1'b1);
    checks++; if (dout !== 8'h27) begin failures++; $display("FAIL cr_read got=%h exp=27", dout); end
    wr(1'b0, 8'h55);
    checks++; if (dout !== 8'h27) begin failures++; $display("FAIL ddr_hold got=%h exp=27", dout); end
    checks++; if (key_ready !== 1'b0) begin failures++; $display("FAIL ddr_ready got=%b exp=0", key_ready); end
    rd(1'b1);
    checks++; if (dout !== 8'h27) begin failures++; $display("FAIL ddr_cr got=%h exp=27", dout); end
    rd(1'b0);
    checks++; if (dout !== 8'hDA) begin failures++; $display("FAIL ddr_lastkey got=%h exp=DA", dout); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) push(7'(8'h61 + i));
    checks++; if (key_ready !== 1'b1) begin failures++; $display("FAIL flush_pre got=%b exp=1", key_ready); end
    flush = 1'b1; key_valid = 1'b1; key_ascii = 7'h66;
    tick();
    flush = 1'b0; key_valid = 1'b0;
    checks++; if (key_ready !== 1'b0) begin failures++; $display("FAIL flush_empty got=%b exp=0", key_ready); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL flush_ovf got=%b exp=0", overflow); end
    rd(1'b0);
    checks++; if (dout !== 8'hDA) begin failures++; $display("FAIL flush_lastkey got=%h exp=DA", dout); end
    push(7'h70);
    rd(1'b0);
    checks++; if (dout !== 8'hF0) begin failures++; $display("FAIL flush_repush got=%h exp=F0", dout); end
  endtask

  task automatic test_reset_mid();
    push(7'h31);
    push(7'h32);
    reset = 1'b1; key_valid = 1'b1; key_ascii = 7'h33;
    tick();
    reset = 1'b0; key_valid = 1'b0;
    checks++; if (key_ready !== 1'b0) begin failures++; $display("FAIL rstmid_ready got=%b exp=0", key_ready); end
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL rstmid_dout got=%h exp=00", dout); end
    rd(1'b1);
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL rstmid_cr got=%h exp=00", dout); end
    rd(1'b0);
    checks++; if (dout !== 8'h80) begin failures++; $display("FAIL rstmid_kbd got=%h exp=80", dout); end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_overflow();
    test_back_to_back();
    test_cr_write();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
